// File: rtl/ir_pkg.sv
// Shared instruction-format constants and opcode encoding for the IR queue
// and the control unit's field decoder.
package ir_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 4;
  localparam int OPC_W_DEF = 5;
  localparam int REG_W_DEF = 4;

  localparam int OPC_LSB = WIDTH_DEF - OPC_W_DEF;
  localparam int RA_LSB  = OPC_LSB - REG_W_DEF;
  localparam int RB_LSB  = RA_LSB - REG_W_DEF;
  localparam int RC_LSB  = RB_LSB - REG_W_DEF;

  // The constant field overlaps rc: it spans everything below rb.
  function automatic int c_width(input int width, input int opc_w, input int reg_w);
    return width - opc_w - 2 * reg_w;
  endfunction

  localparam int C_W_DEF = c_width(WIDTH_DEF, OPC_W_DEF, REG_W_DEF);

  typedef enum logic [OPC_W_DEF-1:0] {
    OP_LD   = 5'd0,
    OP_LDI  = 5'd1,
    OP_ST   = 5'd2,
    OP_LDR  = 5'd3,
    OP_STR  = 5'd4,
    OP_ADD  = 5'd5,
    OP_SUB  = 5'd6,
    OP_AND  = 5'd7,
    OP_OR   = 5'd8,
    OP_SHR  = 5'd9,
    OP_SHL  = 5'd10,
    OP_BR   = 5'd11,
    OP_BRL  = 5'd12,
    OP_NOP  = 5'd30,
    OP_STOP = 5'd31
  } opcode_e;

endpackage

// File: rtl/ir_field_decode.sv
// Combinational split of an instruction word into opcode, register selects
// and the sign-extended constant field.
module ir_field_decode
  import ir_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPC_W = OPC_W_DEF,
  parameter int REG_W = REG_W_DEF
) (
  input  logic [WIDTH-1:0] word,
  output logic [OPC_W-1:0] opcode,
  output logic [REG_W-1:0] ra,
  output logic [REG_W-1:0] rb,
  output logic [REG_W-1:0] rc,
  output logic [WIDTH-1:0] cext
);

  localparam int C_W = c_width(WIDTH, OPC_W, REG_W);

  assign opcode = word[WIDTH-1 -: OPC_W];
  assign ra     = word[WIDTH-OPC_W-1 -: REG_W];
  assign rb     = word[WIDTH-OPC_W-REG_W-1 -: REG_W];
  assign rc     = word[WIDTH-OPC_W-2*REG_W-1 -: REG_W];
  assign cext   = {{(WIDTH-C_W){word[C_W-1]}}, word[C_W-1:0]};

endmodule

// File: rtl/ir_queue.sv
// DEPTH-entry instruction prefetch queue with decoded head-of-queue IR.
// Define IR_QUEUE_BYPASS_EN to let an empty-queue push appear on the outputs combinationally.
module ir_queue
  import ir_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int OPC_W = OPC_W_DEF,
  parameter int REG_W = REG_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     IRin,
  input  logic [WIDTH-1:0]         busdata,
  input  logic                     advance,
  input  logic                     flush,
  output logic [WIDTH-1:0]         IRvalue,
  output logic                     ir_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [OPC_W-1:0]         opcode,
  output logic [REG_W-1:0]         ra,
  output logic [REG_W-1:0]         rb,
  output logic [REG_W-1:0]         rc,
  output logic [WIDTH-1:0]         Zlow,
  output logic                     ovf_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic             empty;
  logic             pop_ok;
  logic             push_ok;
  logic             overflow;
  logic             bypass;
  logic             consume;
  logic [WIDTH-1:0] head;

  assign empty  = (cnt == '0);
  assign full   = (cnt == CNT_W'(DEPTH));
  assign pop_ok = advance && !empty && !flush;

`ifdef IR_QUEUE_BYPASS_EN
  // Gated by reset so the outputs stay 0 while reset is held.
  assign bypass  = IRin && empty && !flush && reset;
  assign consume = bypass && advance;
`else
  assign bypass  = 1'b0;
  assign consume = 1'b0;
`endif

  assign push_ok  = IRin && !flush && !consume && (!full || pop_ok);
  assign overflow = IRin && !flush && full && !pop_ok;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CNT_W'(push_ok) - CNT_W'(pop_ok);
      if (overflow)
        ovf <= 1'b1;
    end
  end

  // Storage is deliberately not reset; occupancy alone says what is live.
  always_ff @(posedge clock) begin
    if (push_ok)
      mem[wr_ptr] <= busdata;
  end

  always_comb begin
    head = '0;
    if (bypass)
      head = busdata;
    else if (!empty)
      head = mem[rd_ptr];
  end

  assign IRvalue  = head;
  assign ir_valid = !empty || bypass;
  assign count    = cnt;
  assign ovf_err  = ovf;

  ir_field_decode #(
    .WIDTH (WIDTH),
    .OPC_W (OPC_W),
    .REG_W (REG_W)
  ) u_decode (
    .word   (head),
    .opcode (opcode),
    .ra     (ra),
    .rb     (rb),
    .rc     (rc),
    .cext   (Zlow)
  );

endmodule
